fmps_readout_sequencer: RTL and testbench

- Downstream consumer of the FMPS read link, in the sysClk domain.
- At each cycle start it latches the FMPS presence bitmap and scans it in ascending index order. It fetches each present FMPS word through the read link's 1-cycle-latency readout port and streams the words out as one AXI-stream packet.
- Each word is checked for invalid flags, the reserved bit and an index mismatch. Error and word counters are kept for the CSR.

---
 rtl/fmps_readout_sequencer_pkg.sv | 27 ++
 rtl/fmps_readout_sequencer_if.sv | 30 +++
 rtl/fmps_readout_sequencer_priority_encoder.sv | 26 ++
 rtl/fmps_readout_sequencer.sv | 225 ++++++++++++++++++++++
 tb/tb_fmps_readout_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fmps_readout_sequencer_pkg.sv
// fmps_pkg: shared definitions for the FMPS readout sequencer.
//   - bit positions of the fields inside a 32-bit FMPS word
//   - magic value placed in the optional packet header word
//   - sequencer state encoding
// Optional feature macro: FMPS_READOUT_HEADER_EN (adds the HEADER state).
package fmps_pkg;

  localparam int FMPS2CC = 31;  // invalidFMPS2CC flag
  localparam int CC2CC   = 30;  // invalidCC2CC flag
  localparam int RSVD    = 29;  // reserved, must be zero
  localparam int IDX_HI  = 28;  // embedded FMPS index, upper bit
  localparam int IDX_LO  = 24;  // embedded FMPS index, lower bit

  localparam logic [15:0] HEADER_MAGIC = 16'hB6CF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_SETTLE,
    ST_LOAD,
    ST_EMIT
`ifdef FMPS_READOUT_HEADER_EN
    , ST_HEADER
`endif
  } state_t;

endpackage

// File: rtl/fmps_readout_sequencer_if.sv
// fmps_readout_sequencer_if: AXI-stream style output bus of the sequencer.
//   M_TDATA  : stream word
//   M_TVALID : word valid
//   M_TLAST  : last word of the packet
//   M_TREADY : sink ready
// Modports: master (sequencer side), slave (sink side).
interface fmps_readout_sequencer_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic [DATA_WIDTH-1:0] M_TDATA;
  logic                  M_TVALID;
  logic                  M_TLAST;
  logic                  M_TREADY;

  modport master (
    output M_TDATA,
    output M_TVALID,
    output M_TLAST,
    input  M_TREADY
  );

  modport slave (
    input  M_TDATA,
    input  M_TVALID,
    input  M_TLAST,
    output M_TREADY
  );

endinterface

// File: rtl/fmps_readout_sequencer_priority_encoder.sv
// fmps_priority_encoder: purely combinational lowest-set-bit finder.
// Ports:
//   mask   in  1<<INDEX_WIDTH  bits to search
//   lowest out INDEX_WIDTH     index of the lowest set bit (0 when mask is 0)
//   any    out 1               at least one bit of mask is set
module fmps_priority_encoder #(
  parameter int INDEX_WIDTH = 5
) (
  input  logic [(1<<INDEX_WIDTH)-1:0] mask,
  output logic [INDEX_WIDTH-1:0]      lowest,
  output logic                        any
);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    lowest = '0;
    for (int i = (1 << INDEX_WIDTH) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lowest = INDEX_WIDTH'(i);
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/fmps_readout_sequencer.sv
// fmps_readout_sequencer: on each cycleStart, latches the FMPS presence
// bitmap, fetches every present FMPS word (ascending index) through the
// 1-cycle-latency read-link port and streams them as one packet.
// Words with set flag/reserved bits or a wrong embedded index are counted
// as errors but still forwarded unchanged.
// Optional feature macro: FMPS_READOUT_HEADER_EN -- prefixes each nonempty
// packet with {HEADER_MAGIC, 8'd0, cycle counter}.
// Ports:
//   sysClk, sysReset_n        clock, asynchronous active-low reset
//   cycleStart, fmpsBitmap    scan trigger and presence bitmap
//   readoutAddress/readoutFMPS read-link DPRAM address and data (+1 cycle)
//   m_axis                    output stream (master modport)
//   busy, doneStrobe          scan in progress / end-of-scan pulse
//   wordCount                 words sent in the last completed scan
//   errorCount, overrun       saturating bad-word count, sticky overrun
//   clearStatus               clears errorCount and overrun
module fmps_readout_sequencer
  import fmps_pkg::*;
#(
  parameter int INDEX_WIDTH = 5,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                         sysClk,
  input  logic                         sysReset_n,
  input  logic                         cycleStart,
  input  logic [(1<<INDEX_WIDTH)-1:0]  fmpsBitmap,
  output logic [INDEX_WIDTH-1:0]       readoutAddress,
  input  logic [DATA_WIDTH-1:0]        readoutFMPS,
  fmps_readout_sequencer_if.master     m_axis,
  output logic                         busy,
  output logic                         doneStrobe,
  output logic [INDEX_WIDTH:0]         wordCount,
  output logic [15:0]                  errorCount,
  output logic                         overrun,
  input  logic                         clearStatus
);

  localparam int MASK_W = 1 << INDEX_WIDTH;

  state_t                  state_reg, state_next;
  logic [MASK_W-1:0]       mask_reg, mask_next;
  logic [INDEX_WIDTH-1:0]  addr_reg, addr_next;
  logic [DATA_WIDTH-1:0]   tdata_reg, tdata_next;
  logic                    tvalid_reg, tvalid_next;
  logic                    tlast_reg, tlast_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic [INDEX_WIDTH:0]    wcount_reg, wcount_next;
  logic [INDEX_WIDTH:0]    wrun_reg, wrun_next;
  logic [15:0]             err_reg, err_next;
  logic                    overrun_reg, overrun_next;
`ifdef FMPS_READOUT_HEADER_EN
  logic [7:0]              cyc_reg, cyc_next;
`endif

  logic [MASK_W-1:0]       rest_mask;
  logic [MASK_W-1:0]       enc_mask;
  logic [INDEX_WIDTH-1:0]  enc_lowest;
  logic                    enc_any;
  logic                    word_bad;

  // Mask with the bit being loaded removed; empty means this word is last.
  assign rest_mask = mask_reg & ~({{(MASK_W-1){1'b0}}, 1'b1} << addr_reg);

  // One encoder serves both uses: SEEK needs the lowest remaining index,
  // LOAD needs to know whether anything remains after the current bit.
  assign enc_mask = (state_reg == ST_LOAD) ? rest_mask : mask_reg;

  fmps_priority_encoder #(
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_prio (
    .mask   (enc_mask),
    .lowest (enc_lowest),
    .any    (enc_any)
  );

  always_ff @(posedge sysClk or negedge sysReset_n) begin
    if (!sysReset_n) begin
      state_reg   <= ST_IDLE;
      mask_reg    <= '0;
      addr_reg    <= '0;
      tdata_reg   <= '0;
      tvalid_reg  <= 1'b0;
      tlast_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      wcount_reg  <= '0;
      wrun_reg    <= '0;
      err_reg     <= '0;
      overrun_reg <= 1'b0;
`ifdef FMPS_READOUT_HEADER_EN
      cyc_reg     <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      mask_reg    <= mask_next;
      addr_reg    <= addr_next;
      tdata_reg   <= tdata_next;
      tvalid_reg  <= tvalid_next;
      tlast_reg   <= tlast_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      wcount_reg  <= wcount_next;
      wrun_reg    <= wrun_next;
      err_reg     <= err_next;
      overrun_reg <= overrun_next;
`ifdef FMPS_READOUT_HEADER_EN
      cyc_reg     <= cyc_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    mask_next    = mask_reg;
    addr_next    = addr_reg;
    tdata_next   = tdata_reg;
    tvalid_next  = tvalid_reg;
    tlast_next   = tlast_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    wcount_next  = wcount_reg;
    wrun_next    = wrun_reg;
    err_next     = err_reg;
    overrun_next = overrun_reg;
    word_bad     = 1'b0;
`ifdef FMPS_READOUT_HEADER_EN
    cyc_next     = cyc_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
        if (cycleStart) begin
          mask_next = fmpsBitmap;
          wrun_next = '0;
`ifdef FMPS_READOUT_HEADER_EN
          cyc_next  = cyc_reg + 8'd1;
`endif
          if (|fmpsBitmap) begin
            busy_next = 1'b1;
`ifdef FMPS_READOUT_HEADER_EN
            tdata_next  = DATA_WIDTH'({HEADER_MAGIC, 8'd0, cyc_reg});
            tvalid_next = 1'b1;
            tlast_next  = 1'b0;
            state_next  = ST_HEADER;
`else
            state_next  = ST_SEEK;
`endif
          end else begin
            // Empty set: finish immediately with an empty scan.
            done_next   = 1'b1;
            wcount_next = '0;
            busy_next   = 1'b0;
          end
        end
      end
`ifdef FMPS_READOUT_HEADER_EN
      ST_HEADER: begin
        if (m_axis.M_TREADY) begin
          tvalid_next = 1'b0;
          state_next  = ST_SEEK;
        end
      end
`endif
      ST_SEEK: begin
        addr_next  = enc_lowest;
        state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_next = ST_LOAD;
      end
      ST_LOAD: begin
        tdata_next  = readoutFMPS;
        tvalid_next = 1'b1;
        tlast_next  = !enc_any;
        mask_next   = rest_mask;
        word_bad    = readoutFMPS[FMPS2CC] | readoutFMPS[CC2CC] |
                      readoutFMPS[RSVD] |
                      (readoutFMPS[IDX_HI:IDX_LO] != 5'(addr_reg));
        state_next  = ST_EMIT;
      end
      ST_EMIT: begin
        if (m_axis.M_TREADY) begin
          wrun_next   = wrun_reg + 1'b1;
          tvalid_next = 1'b0;
          if (tlast_reg) begin
            done_next   = 1'b1;
            wcount_next = wrun_reg + 1'b1;
            busy_next   = 1'b0;
            state_next  = ST_IDLE;
          end else begin
            state_next  = ST_SEEK;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // A new set arriving mid-scan is dropped; the current scan carries on.
    if (cycleStart && (state_reg != ST_IDLE)) begin
      overrun_next = 1'b1;
    end
    if (word_bad && (err_reg != 16'hFFFF)) begin
      err_next = err_reg + 16'd1;
    end
    // Clearing takes priority over a simultaneous error or overrun.
    if (clearStatus) begin
      err_next     = '0;
      overrun_next = 1'b0;
    end
  end

  assign readoutAddress  = addr_reg;
  assign m_axis.M_TDATA  = tdata_reg;
  assign m_axis.M_TVALID = tvalid_reg;
  assign m_axis.M_TLAST  = tlast_reg;
  assign busy            = busy_reg;
  assign doneStrobe      = done_reg;
  assign wordCount       = wcount_reg;
  assign errorCount      = err_reg;
  assign overrun         = overrun_reg;

endmodule

// File: tb/tb_fmps_readout_sequencer.sv
// Testbench for fmps_readout_sequencer: DPRAM model with 1-cycle read
// latency, expected beats queued at cycleStart and popped on handshakes.
// Build with +define+FMPS_READOUT_HEADER_EN to exercise the header word.
`timescale 1ns/1ps
module tb_fmps_readout_sequencer;

  localparam int IW = 5;
  localparam int DW = 32;
  localparam int NW = 1 << IW;

`ifdef FMPS_READOUT_HEADER_EN
  localparam int LAT_EXP = 1;
`else
  localparam int LAT_EXP = 4;
`endif

  logic          sysClk      = 1'b0;
  logic          sysReset_n  = 1'b0;
  logic          cycleStart  = 1'b0;
  logic          clearStatus = 1'b0;
  logic [NW-1:0] fmpsBitmap  = '0;
  logic [IW-1:0] readoutAddress;
  logic [DW-1:0] readoutFMPS = '0;
  logic          busy;
  logic          doneStrobe;
  logic          overrun;
  logic [IW:0]   wordCount;
  logic [15:0]   errorCount;

  fmps_readout_sequencer_if #(.DATA_WIDTH(DW)) axis ();

  fmps_readout_sequencer #(
    .INDEX_WIDTH (IW),
    .DATA_WIDTH  (DW)
  ) dut (
    .sysClk         (sysClk),
    .sysReset_n     (sysReset_n),
    .cycleStart     (cycleStart),
    .fmpsBitmap     (fmpsBitmap),
    .readoutAddress (readoutAddress),
    .readoutFMPS    (readoutFMPS),
    .m_axis         (axis),
    .busy           (busy),
    .doneStrobe     (doneStrobe),
    .wordCount      (wordCount),
    .errorCount     (errorCount),
    .overrun        (overrun),
    .clearStatus    (clearStatus)
  );

  always #5 sysClk = ~sysClk;

  // Read-link DPRAM: data follows the address by one clock.
  logic [DW-1:0] mem [NW];
  always @(posedge sysClk) readoutFMPS <= mem[readoutAddress];

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;
  beat_t sb_q[$];

  int total = 0;
  int bad   = 0;
  int exp_err = 0;
  int hdr_cnt = 0;
  int done_seen = 0;
  int ready_mode = 1;  // 0: low, 1: high, 2: random

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  function automatic logic [31:0] mkword(input int idx, input logic [2:0] flags, input logic [4:0] tag);
    return {flags, tag, 24'(idx * 24'h001357 + 24'h0000A5)};
  endfunction

  function automatic bit word_is_bad(input logic [31:0] w, input int idx);
    return (w[31:29] != 3'b000) || (w[28:24] != 5'(idx));
  endfunction

  // Sink ready, changed just after each rising edge.
  initial begin
    axis.M_TREADY = 1'b0;
    forever begin
      @(posedge sysClk);
      #1;
      if (ready_mode == 2) axis.M_TREADY = 1'($urandom_range(0, 1));
      else                 axis.M_TREADY = (ready_mode == 1);
    end
  end

  // Output monitor: scoreboard pops and hold-under-stall checks.
  logic        stall_prev = 1'b0;
  logic [31:0] data_prev  = '0;
  logic        last_prev  = 1'b0;
  always @(negedge sysClk) begin
    beat_t b;
    if (!sysReset_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", axis.M_TVALID, 1'b1);
        check("hold_data", axis.M_TDATA, data_prev);
        check("hold_last", axis.M_TLAST, last_prev);
      end
      if (axis.M_TVALID && axis.M_TREADY) begin
        check("beat_pending", sb_q.size() > 0, 1'b1);
        if (sb_q.size() > 0) begin
          b = sb_q.pop_front();
          check("beat_data", axis.M_TDATA, b.data);
          check("beat_last", axis.M_TLAST, b.last);
        end
      end
      stall_prev = axis.M_TVALID && !axis.M_TREADY;
      data_prev  = axis.M_TDATA;
      last_prev  = axis.M_TLAST;
      if (doneStrobe) done_seen++;
    end
  end

  // Pulse cycleStart for one clock (returns just after the accepting edge)
  // and queue the packet the DUT should produce.
  task automatic start_scan(input logic [31:0] bm);
    int hi;
    hi = -1;
    @(posedge sysClk);
    #1;
    fmpsBitmap = bm;
    cycleStart = 1'b1;
    for (int i = 0; i < NW; i++) if (bm[i]) hi = i;
    if (hi >= 0) begin
`ifdef FMPS_READOUT_HEADER_EN
      sb_q.push_back('{data: {16'hB6CF, 8'h00, 8'(hdr_cnt)}, last: 1'b0});
`endif
      for (int i = 0; i < NW; i++) begin
        if (bm[i]) begin
          sb_q.push_back('{data: mem[i], last: (i == hi)});
          if (word_is_bad(mem[i], i)) exp_err++;
        end
      end
    end
    hdr_cnt++;
    @(posedge sysClk);
    #1;
    cycleStart = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int n);
    n = 0;
    do begin
      @(negedge sysClk);
      n++;
    end while (!axis.M_TVALID && n < 200);
    check({tag, "_tvalid"}, axis.M_TVALID, 1'b1);
  endtask

  task automatic wait_done(input string tag, input int wc_exp);
    int  n;
    bit  got;
    n   = 0;
    got = 1'b0;
    while (!got && n < 2000) begin
      @(negedge sysClk);
      n++;
      got = doneStrobe;
    end
    check({tag, "_done"}, got, 1'b1);
    check({tag, "_wordcount"}, wordCount, wc_exp);
    check({tag, "_errcount"}, errorCount, exp_err);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  task automatic pulse_clear();
    @(posedge sysClk);
    #1;
    clearStatus = 1'b1;
    @(posedge sysClk);
    #1;
    clearStatus = 1'b0;
    exp_err = 0;
  endtask

  initial begin
    int d0;
    int lat;
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int lat;
    for (int i = 0; i < NW; i++) mem[i] = mkword(i, 3'b000, 5'(i));
    ready_mode = 1;

    // Reset state.
    repeat (3) @(posedge sysClk);
    @(negedge sysClk);
    check("rst_tvalid", axis.M_TVALID, 1'b0);
    check("rst_tdata", axis.M_TDATA, 32'h0);
    check("rst_tlast", axis.M_TLAST, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", doneStrobe, 1'b0);
    check("rst_wordcount", wordCount, 0);
    check("rst_errcount", errorCount, 0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_addr", readoutAddress, 0);
    @(posedge sysClk);
    #1;
    sysReset_n = 1'b1;

    // 12 contiguous good words, ready held high.
    d0 = done_seen;
    start_scan(32'h0000_0FFF);
    wait_valid("t1", lat);
    check("t1_latency", lat, LAT_EXP);
    wait_done("t1", 12);
    repeat (4) @(negedge sysClk);
    check("t1_done_once", done_seen - d0, 1);

    // First and last index with random backpressure.
    ready_mode = 2;
    start_scan(32'h8000_0001);
    wait_done("t2", 2);
    ready_mode = 1;

    // Empty bitmap: immediate done, no beats.
    start_scan(32'h0);
    @(negedge sysClk);
    check("t3_done_next", doneStrobe, 1'b1);
    check("t3_wordcount", wordCount, 0);
    check("t3_busy", busy, 1'b0);
    repeat (6) @(negedge sysClk);
    check("t3_no_valid", axis.M_TVALID, 1'b0);

    // Three bad words among four, then clear.
    mem[2] = mkword(2, 3'b100, 5'd2);
    mem[5] = mkword(5, 3'b000, 5'd6);
    mem[7] = mkword(7, 3'b001, 5'd7);
    start_scan(32'h0000_00A5);
    wait_done("t4", 4);
    check("t4_errcount3", errorCount, 3);
    pulse_clear();
    @(negedge sysClk);
    check("t4_cleared", errorCount, 0);

    // clearStatus on the same edge as a bad word's load: clear wins.
    mem[0] = mkword(0, 3'b010, 5'd0);
    start_scan(32'h0000_0001);
`ifdef FMPS_READOUT_HEADER_EN
    @(posedge sysClk);
`endif
    @(posedge sysClk);
    @(posedge sysClk);
    #1;
    clearStatus = 1'b1;
    @(posedge sysClk);
    #1;
    clearStatus = 1'b0;
    exp_err = 0;
    wait_done("t5", 1);
    mem[0] = mkword(0, 3'b000, 5'd0);

    // Second cycleStart while stalled: overrun, first packet intact.
    ready_mode = 0;
    start_scan(32'h0000_0003);
    wait_valid("t6", lat);
    repeat (3) @(negedge sysClk);
    @(posedge sysClk);
    #1;
    fmpsBitmap = 32'h0000_00FF;
    cycleStart = 1'b1;
    @(posedge sysClk);
    #1;
    cycleStart = 1'b0;
    @(negedge sysClk);
    check("t6_overrun", overrun, 1'b1);
    check("t6_busy", busy, 1'b1);
    ready_mode = 1;
    wait_done("t6", 2);
    check("t6_overrun_sticky", overrun, 1'b1);
    pulse_clear();
    @(negedge sysClk);
    check("t6_overrun_clr", overrun, 1'b0);

    // Reset in the middle of a stalled packet.
    ready_mode = 0;
    start_scan(32'h0000_00F0);
    wait_valid("t7", lat);
    repeat (2) @(negedge sysClk);
    sysReset_n = 1'b0;
    #1;
    check("t7_rst_tvalid", axis.M_TVALID, 1'b0);
    check("t7_rst_tlast", axis.M_TLAST, 1'b0);
    check("t7_rst_busy", busy, 1'b0);
    sb_q.delete();
    exp_err = 0;
    hdr_cnt = 0;
    ready_mode = 1;
    @(posedge sysClk);
    #1;
    sysReset_n = 1'b1;

    // Top index alone after reset.
    start_scan(32'h8000_0000);
    wait_done("t8", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
